// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: branch-type encodings and a
// constant log2 helper used for parameter-derived widths.
package pc_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_JMP  = 3'd5;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Pop takes precedence over push; when full, a push
// overwrites the oldest entry and sets the sticky overflow flag.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    tp_q, tp_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = tp_q + AW'(1);
        if (!stall) begin
            if (pop) begin
                if (count_q != '0) begin
                    tp_d    = tp_q - AW'(1);
                    count_d = count_q - (AW + 1)'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (push) begin
                tp_d  = tp_q + AW'(1);
                wr_en = 1'b1;
                // Full stack: the slot ahead of the top holds the oldest entry.
                if (count_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + (AW + 1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= push_data;
            end
        end
    end

    assign top   = mem_q[tp_q];
    assign empty = (count_q == '0);
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, sequential/target adders, branch condition
// decode and next-PC selection, with a return-address stack for CALL/RET.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W         = 32,
    parameter int unsigned     OFF_W        = 8,
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic [2:0]       BR_TYPE,
    input  logic             ZERO,
    input  logic             NEG,
    input  logic [OFF_W-1:0] OFFSET,
    input  logic             CALL,
    input  logic             RET,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  NEXT_PC,
    output logic             TAKEN,
    output logic             RAS_OVF,
    output logic             RAS_UNF
);

    localparam int unsigned SHIFT = clog2(STEP);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] off_ext;
    logic            cond;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_push;
    logic [PC_W-1:0] next_pc;
    logic            taken;

    // Word offset, sign-extended to PC width, then scaled to bytes.
    assign off_ext = PC_W'($signed(OFFSET));
    assign seq     = pc_q + PC_W'(STEP);
    assign tgt     = seq + (off_ext << SHIFT);

    always_comb begin
        cond = 1'b0;
        case (BR_TYPE)
            BR_EQ:   cond = ZERO;
            BR_NE:   cond = ~ZERO;
            BR_LT:   cond = NEG;
            BR_GE:   cond = ~NEG;
            BR_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = seq;
        taken   = 1'b0;
        if (RET) begin
            if (!ras_empty) begin
                next_pc = ras_top;
                taken   = 1'b1;
            end
        end else if (CALL) begin
            next_pc = tgt;
            taken   = 1'b1;
        end else if (cond) begin
            next_pc = tgt;
            taken   = 1'b1;
        end
    end

    // RET wins over a simultaneous CALL, so the push is suppressed.
    assign ras_push = CALL & ~RET;

    ras_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .reset     (RESET),
        .stall     (STALL),
        .push      (ras_push),
        .pop       (RET),
        .push_data (seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .ovf       (RAS_OVF),
        .unf       (RAS_UNF)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_VECTOR;
        end else if (!STALL) begin
            pc_q <= next_pc;
        end
    end

    assign PC      = pc_q;
    assign NEXT_PC = next_pc;
    assign TAKEN   = taken;

endmodule
